mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl_pkg.sv | 34 +++
 rtl/mem_ctrl.sv | 246 ++++++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared constants for the memory controller slice.
//   ENABLE/DISABLE   : request and completion-pulse levels
//   READ/WRITE       : access direction on the core and RAM sides
//   BUSY/NOT_BUSY    : ownership flag levels
//   ADDR_RANGE/DATA_RANGE : core-side address and data widths
//   RAM_ADDR_W       : width of the byte address presented to the RAM
// clamp_len maps a raw 3-bit length field onto the lengths the controller serves.
package mem_ctrl_pkg;

   localparam logic ENABLE   = 1'b1;
   localparam logic DISABLE  = 1'b0;
   localparam logic READ     = 1'b0;
   localparam logic WRITE    = 1'b1;
   localparam logic BUSY     = 1'b1;
   localparam logic NOT_BUSY = 1'b0;

   localparam int ADDR_RANGE = 32;
   localparam int DATA_RANGE = 32;
   localparam int RAM_ADDR_W = 17;

   localparam logic [2:0] FETCH_LEN = 3'd4;

   // Lengths above a full word are served as a full word; 0..4 pass through.
   function automatic logic [2:0] clamp_len(input logic [2:0] len);
      logic [2:0] res;
      if (len > 3'd4) begin
         res = 3'd4;
      end else begin
         res = len;
      end
      return res;
   endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller arbitrating an instruction-fetch port (IF)
// and a data-access port (MEM) onto a single 8-bit synchronous RAM.
// Ports:
//   clk_in, rst_in          : clock, active-low reset (async assert, sync release)
//   IF_E_in, IF_addr_in     : 4-byte fetch request and byte address
//   MEM_E_in, MEM_rw_in     : data request and direction (READ=0, WRITE=1)
//   MEM_addr_in, MEM_data_in, MEM_len_in : byte address, store data, length 1..4
//   ram_data_in             : RAM read byte, valid one cycle after its address
//   ram_addr_out, ram_rw_out, ram_data_out : RAM byte address, direction, write byte
//   busyIF_out, busyMEM_out : which port currently owns the controller
//   IF_dataE_out, MEM_dataE_out : one-cycle completion pulse per transaction
//   data_out                : assembled read word, zero outside a completion pulse
module mem_ctrl
   import mem_ctrl_pkg::*;
(
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  IF_E_in,
   input  logic [ADDR_RANGE-1:0] IF_addr_in,
   input  logic                  MEM_E_in,
   input  logic                  MEM_rw_in,
   input  logic [ADDR_RANGE-1:0] MEM_addr_in,
   input  logic [DATA_RANGE-1:0] MEM_data_in,
   input  logic [2:0]            MEM_len_in,
   input  logic [7:0]            ram_data_in,
   output logic [RAM_ADDR_W-1:0] ram_addr_out,
   output logic                  ram_rw_out,
   output logic [7:0]            ram_data_out,
   output logic                  busyIF_out,
   output logic                  busyMEM_out,
   output logic                  IF_dataE_out,
   output logic                  MEM_dataE_out,
   output logic [DATA_RANGE-1:0] data_out
);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_BUSY_IF  = 2'd1,
      ST_BUSY_MEM = 2'd2,
      ST_DONE     = 2'd3
   } state_t;

   localparam logic OWN_IF  = 1'b0;
   localparam logic OWN_MEM = 1'b1;

   logic [1:0]            rst_sync_r;
   logic                  rst_n_s;

   state_t                state_r,     state_nxt_s;
   logic                  owner_r,     owner_nxt_s;
   // cnt_r holds the number of edges elapsed since acceptance while busy
   logic [2:0]            cnt_r,       cnt_nxt_s;
   logic [ADDR_RANGE-1:0] base_r,      base_nxt_s;
   logic [2:0]            len_r,       len_nxt_s;
   logic                  rw_r,        rw_nxt_s;
   logic [DATA_RANGE-1:0] wdata_r,     wdata_nxt_s;
   logic [DATA_RANGE-1:0] asm_r,       asm_nxt_s;
   logic [RAM_ADDR_W-1:0] ram_addr_r,  ram_addr_nxt_s;
   logic                  ram_rw_r,    ram_rw_nxt_s;
   logic [7:0]            ram_wdata_r, ram_wdata_nxt_s;
   logic                  busy_if_r,   busy_if_nxt_s;
   logic                  busy_mem_r,  busy_mem_nxt_s;
   logic                  if_de_r,     if_de_nxt_s;
   logic                  mem_de_r,    mem_de_nxt_s;
   logic [DATA_RANGE-1:0] data_r,      data_nxt_s;

   logic                  mem_req_s;

   // Reset synchronizer: asserts immediately, releases on the second clock edge.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         rst_sync_r <= 2'b00;
      end else begin
         rst_sync_r <= {rst_sync_r[0], 1'b1};
      end
   end

   assign rst_n_s = rst_sync_r[1];

   // A zero-length data request is not a request, so IF may win in that case.
   assign mem_req_s = (MEM_E_in == ENABLE) && (MEM_len_in != 3'd0);

   // Next-state, datapath and registered-output computation.
   always_comb begin
      state_nxt_s     = state_r;
      owner_nxt_s     = owner_r;
      cnt_nxt_s       = cnt_r;
      base_nxt_s      = base_r;
      len_nxt_s       = len_r;
      rw_nxt_s        = rw_r;
      wdata_nxt_s     = wdata_r;
      asm_nxt_s       = asm_r;
      ram_addr_nxt_s  = ram_addr_r;
      ram_rw_nxt_s    = READ;
      ram_wdata_nxt_s = ram_wdata_r;
      if_de_nxt_s     = DISABLE;
      mem_de_nxt_s    = DISABLE;
      data_nxt_s      = 32'h0000_0000;

      case (state_r)
         ST_IDLE: begin
            if (mem_req_s) begin
               state_nxt_s     = ST_BUSY_MEM;
               owner_nxt_s     = OWN_MEM;
               base_nxt_s      = MEM_addr_in;
               len_nxt_s       = clamp_len(MEM_len_in);
               rw_nxt_s        = MEM_rw_in;
               wdata_nxt_s     = MEM_data_in;
               cnt_nxt_s       = 3'd1;
               asm_nxt_s       = 32'h0000_0000;
               ram_addr_nxt_s  = MEM_addr_in[RAM_ADDR_W-1:0];
               ram_rw_nxt_s    = MEM_rw_in;
               ram_wdata_nxt_s = MEM_data_in[7:0];
            end else if (IF_E_in == ENABLE) begin
               state_nxt_s     = ST_BUSY_IF;
               owner_nxt_s     = OWN_IF;
               base_nxt_s      = IF_addr_in;
               len_nxt_s       = FETCH_LEN;
               rw_nxt_s        = READ;
               wdata_nxt_s     = 32'h0000_0000;
               cnt_nxt_s       = 3'd1;
               asm_nxt_s       = 32'h0000_0000;
               ram_addr_nxt_s  = IF_addr_in[RAM_ADDR_W-1:0];
            end else begin
               state_nxt_s     = ST_IDLE;
            end
         end

         ST_BUSY_IF, ST_BUSY_MEM: begin
            if (rw_r == WRITE) begin
               if (cnt_r < len_r) begin
                  // Byte address wraps at 32 bits before truncation to the RAM width.
                  ram_addr_nxt_s  = RAM_ADDR_W'(base_r + {29'd0, cnt_r});
                  ram_rw_nxt_s    = WRITE;
                  ram_wdata_nxt_s = 8'(wdata_r >> {cnt_r, 3'b000});
                  cnt_nxt_s       = cnt_r + 3'd1;
               end else begin
                  state_nxt_s = ST_DONE;
                  if (owner_r == OWN_MEM) begin
                     mem_de_nxt_s = ENABLE;
                  end else begin
                     if_de_nxt_s  = ENABLE;
                  end
               end
            end else begin
               if (cnt_r < len_r) begin
                  ram_addr_nxt_s = RAM_ADDR_W'(base_r + {29'd0, cnt_r});
               end else begin
                  ram_addr_nxt_s = ram_addr_r;
               end
               // The byte addressed k cycles ago arrives two edges after it was driven.
               if (cnt_r >= 3'd2) begin
                  asm_nxt_s = asm_r | ({24'd0, ram_data_in} << {cnt_r - 3'd2, 3'b000});
               end else begin
                  asm_nxt_s = asm_r;
               end
               if (cnt_r == (len_r + 3'd1)) begin
                  state_nxt_s = ST_DONE;
                  data_nxt_s  = asm_nxt_s;
                  if (owner_r == OWN_MEM) begin
                     mem_de_nxt_s = ENABLE;
                  end else begin
                     if_de_nxt_s  = ENABLE;
                  end
               end else begin
                  cnt_nxt_s = cnt_r + 3'd1;
               end
            end
         end

         ST_DONE: begin
            // Requests seen here belong to the finishing transaction and are ignored.
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = 3'd0;
         end

         default: begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = 3'd0;
         end
      endcase

      if ((state_nxt_s == ST_BUSY_IF) ||
          ((state_nxt_s == ST_DONE) && (owner_nxt_s == OWN_IF))) begin
         busy_if_nxt_s = BUSY;
      end else begin
         busy_if_nxt_s = NOT_BUSY;
      end

      if ((state_nxt_s == ST_BUSY_MEM) ||
          ((state_nxt_s == ST_DONE) && (owner_nxt_s == OWN_MEM))) begin
         busy_mem_nxt_s = BUSY;
      end else begin
         busy_mem_nxt_s = NOT_BUSY;
      end
   end

   // State, datapath and output registers.
   always_ff @(posedge clk_in or negedge rst_n_s) begin
      if (!rst_n_s) begin
         state_r     <= ST_IDLE;
         owner_r     <= OWN_IF;
         cnt_r       <= 3'd0;
         base_r      <= 32'h0000_0000;
         len_r       <= 3'd0;
         rw_r        <= READ;
         wdata_r     <= 32'h0000_0000;
         asm_r       <= 32'h0000_0000;
         ram_addr_r  <= 17'h0_0000;
         ram_rw_r    <= READ;
         ram_wdata_r <= 8'h00;
         busy_if_r   <= NOT_BUSY;
         busy_mem_r  <= NOT_BUSY;
         if_de_r     <= DISABLE;
         mem_de_r    <= DISABLE;
         data_r      <= 32'h0000_0000;
      end else begin
         state_r     <= state_nxt_s;
         owner_r     <= owner_nxt_s;
         cnt_r       <= cnt_nxt_s;
         base_r      <= base_nxt_s;
         len_r       <= len_nxt_s;
         rw_r        <= rw_nxt_s;
         wdata_r     <= wdata_nxt_s;
         asm_r       <= asm_nxt_s;
         ram_addr_r  <= ram_addr_nxt_s;
         ram_rw_r    <= ram_rw_nxt_s;
         ram_wdata_r <= ram_wdata_nxt_s;
         busy_if_r   <= busy_if_nxt_s;
         busy_mem_r  <= busy_mem_nxt_s;
         if_de_r     <= if_de_nxt_s;
         mem_de_r    <= mem_de_nxt_s;
         data_r      <= data_nxt_s;
      end
   end

   assign ram_addr_out  = ram_addr_r;
   assign ram_rw_out    = ram_rw_r;
   assign ram_data_out  = ram_wdata_r;
   assign busyIF_out    = busy_if_r;
   assign busyMEM_out   = busy_mem_r;
   assign IF_dataE_out  = if_de_r;
   assign MEM_dataE_out = mem_de_r;
   assign data_out      = data_r;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed scenarios plus randomized
// transactions, checked against a transaction-level reference memory.
module tb_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_e;
   logic [31:0] if_addr;
   logic        mem_e;
   logic        mem_rw;
   logic [31:0] mem_addr;
   logic [31:0] mem_data;
   logic [2:0]  mem_len;
   logic [7:0]  ram_rdata;
   logic [16:0] ram_addr;
   logic        ram_rw;
   logic [7:0]  ram_wdata;
   logic        busy_if, busy_mem, if_de, mem_de;
   logic [31:0] data_out;

   int checks   = 0;
   int failures = 0;

   logic [7:0]  ram     [0:131071];
   logic [7:0]  ref_mem [0:131071];
   logic        preload   = 1'b0;
   logic        poke_en   = 1'b0;
   logic [16:0] poke_addr = 17'h0;
   logic [7:0]  poke_data = 8'h0;
   logic [31:0] seed;

   mem_ctrl dut (
      .clk_in        (clk),
      .rst_in        (rst_n),
      .IF_E_in       (if_e),
      .IF_addr_in    (if_addr),
      .MEM_E_in      (mem_e),
      .MEM_rw_in     (mem_rw),
      .MEM_addr_in   (mem_addr),
      .MEM_data_in   (mem_data),
      .MEM_len_in    (mem_len),
      .ram_data_in   (ram_rdata),
      .ram_addr_out  (ram_addr),
      .ram_rw_out    (ram_rw),
      .ram_data_out  (ram_wdata),
      .busyIF_out    (busy_if),
      .busyMEM_out   (busy_mem),
      .IF_dataE_out  (if_de),
      .MEM_dataE_out (mem_de),
      .data_out      (data_out)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] init_byte(input logic [31:0] s, input int i);
      logic [31:0] h;
      h = (32'(i) * 32'h9E37_79B1) ^ s;
      return h[23:16] ^ h[7:0];
   endfunction

   // Synchronous byte RAM: read data valid one cycle after the address is sampled.
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 131072; i++) ram[i] <= init_byte(seed, i);
      end else if (poke_en) begin
         ram[poke_addr] <= poke_data;
      end else if (ram_rw === 1'b1) begin
         ram[ram_addr] <= ram_wdata;
      end
      ram_rdata <= ram[ram_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic poke(input logic [16:0] a, input logic [7:0] d);
      poke_addr = a;
      poke_data = d;
      poke_en   = 1'b1;
      ref_mem[a] = d;
      @(negedge clk);
      poke_en   = 1'b0;
   endtask

   task automatic reset_check();
      chk("rst_busy_if",  {31'd0, busy_if},  32'd0);
      chk("rst_busy_mem", {31'd0, busy_mem}, 32'd0);
      chk("rst_if_de",    {31'd0, if_de},    32'd0);
      chk("rst_mem_de",   {31'd0, mem_de},   32'd0);
      chk("rst_data_out", data_out,          32'd0);
      chk("rst_ram_addr", {15'd0, ram_addr}, 32'd0);
      chk("rst_ram_rw",   {31'd0, ram_rw},   32'd0);
      chk("rst_ram_data", {24'd0, ram_wdata}, 32'd0);
   endtask

   task automatic idle_check();
      @(negedge clk);
      chk("idle_busy", {30'd0, busy_if, busy_mem}, 32'd0);
      chk("idle_de",   {30'd0, if_de, mem_de},     32'd0);
      chk("idle_data", data_out,                   32'd0);
      chk("idle_rw",   {31'd0, ram_rw},            32'd0);
   endtask

   // Follows one transaction from acceptance to its completion pulse and checks
   // every cycle against the byte-serial protocol; returns idle cycles seen first.
   task automatic observe(input bit is_mem, input bit rw, input logic [31:0] base,
                          input logic [31:0] wdata, input int len, output int idle_cycles);
      int          c;
      bit          done;
      logic [31:0] exp_word;
      logic [31:0] wb;
      logic [16:0] a;
      idle_cycles = 0;
      @(negedge clk);
      while (((is_mem ? busy_mem : busy_if) !== 1'b1) && idle_cycles < 20) begin
         idle_cycles++;
         @(negedge clk);
      end
      chk("owner_busy_at_start", {31'd0, is_mem ? busy_mem : busy_if}, 32'd1);
      c    = 0;
      done = 1'b0;
      while (!done && c < 24) begin
         chk("other_port_quiet", {30'd0, is_mem ? busy_if : busy_mem, is_mem ? if_de : mem_de}, 32'd0);
         chk("owner_busy", {31'd0, is_mem ? busy_mem : busy_if}, 32'd1);
         if ((is_mem ? mem_de : if_de) === 1'b1) begin
            done = 1'b1;
            chk("rw_read_at_done", {31'd0, ram_rw}, 32'd0);
         end else begin
            a  = 17'(base + 32'(c));
            wb = wdata >> (8 * c);
            if (rw && c < len) begin
               chk("write_rw",   {31'd0, ram_rw},    32'd1);
               chk("write_addr", {15'd0, ram_addr},  {15'd0, a});
               chk("write_byte", {24'd0, ram_wdata}, {24'd0, wb[7:0]});
            end else begin
               chk("read_rw", {31'd0, ram_rw}, 32'd0);
               if (c < len) chk("read_addr", {15'd0, ram_addr}, {15'd0, a});
            end
            chk("data_zero_no_pulse", data_out, 32'd0);
            c++;
            @(negedge clk);
         end
      end
      chk("latency", c, rw ? len : len + 1);
      if (!rw) begin
         exp_word = 32'd0;
         for (int k = 0; k < len; k++) begin
            a = 17'(base + 32'(k));
            exp_word = exp_word | ({24'd0, ref_mem[a]} << (8 * k));
         end
         chk("read_word", data_out, exp_word);
      end
   endtask

   task automatic mem_txn(input bit rw, input logic [31:0] addr, input logic [31:0] data,
                          input logic [2:0] lenf);
      int          eff;
      int          idle;
      logic [31:0] wb;
      logic [16:0] a;
      eff      = (lenf > 3'd4) ? 4 : int'(lenf);
      mem_e    = 1'b1;
      mem_rw   = rw;
      mem_addr = addr;
      mem_data = data;
      mem_len  = lenf;
      observe(1'b1, rw, addr, data, eff, idle);
      chk("mem_accept_wait", idle, 0);
      mem_e = 1'b0;
      if (rw) begin
         for (int k = 0; k < eff; k++) begin
            a  = 17'(addr + 32'(k));
            wb = data >> (8 * k);
            ref_mem[a] = wb[7:0];
         end
      end
      idle_check();
      if (rw) begin
         for (int k = 0; k < 4; k++) begin
            a = 17'(addr + 32'(k));
            chk("ram_after_write", {24'd0, ram[a]}, {24'd0, ref_mem[a]});
         end
      end
   endtask

   task automatic if_txn(input logic [31:0] addr);
      int idle;
      if_e    = 1'b1;
      if_addr = addr;
      observe(1'b0, 1'b0, addr, 32'd0, 4, idle);
      chk("if_accept_wait", idle, 0);
      if_e = 1'b0;
      idle_check();
   endtask

   initial begin
      int          idle;
      int          kind;
      logic [31:0] r_addr;
      logic [31:0] r_data;
      logic [2:0]  lenf;
      logic [16:0] a;

      seed     = $urandom;
      rst_n    = 1'b0;
      if_e     = 1'b0;
      if_addr  = 32'd0;
      mem_e    = 1'b0;
      mem_rw   = 1'b0;
      mem_addr = 32'd0;
      mem_data = 32'd0;
      mem_len  = 3'd0;
      preload  = 1'b1;
      for (int i = 0; i < 131072; i++) ref_mem[i] = init_byte(seed, i);
      @(negedge clk);
      @(negedge clk);
      preload = 1'b0;
      reset_check();
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // Word read of known bytes.
      poke(17'h100, 8'h11);
      poke(17'h101, 8'h22);
      poke(17'h102, 8'h33);
      poke(17'h103, 8'h44);
      mem_txn(1'b0, 32'h0000_0100, 32'd0, 3'd4);

      // Single-byte store.
      mem_txn(1'b1, 32'h0000_0020, 32'h0000_00A5, 3'd1);
      chk("sb_ram_0x20", {24'd0, ram[17'h20]}, 32'h0000_00A5);

      // Halfword read across the RAM address wrap, from both 17-bit and 32-bit wrap.
      poke(17'h1FFFF, 8'h5A);
      poke(17'h00000, 8'hC3);
      mem_txn(1'b0, 32'h0001_FFFF, 32'd0, 3'd2);
      mem_txn(1'b0, 32'hFFFF_FFFF, 32'd0, 3'd2);

      // Length 3 and clamped lengths.
      mem_txn(1'b1, 32'h0000_0300, 32'hDEAD_BEEF, 3'd3);
      mem_txn(1'b0, 32'h0000_0300, 32'd0, 3'd3);
      mem_txn(1'b1, 32'h0000_0310, 32'h1234_5678, 3'd7);
      mem_txn(1'b0, 32'h0000_0310, 32'd0, 3'd5);

      // Zero-length MEM request is ignored.
      mem_e    = 1'b1;
      mem_rw   = 1'b1;
      mem_addr = 32'h0000_0400;
      mem_len  = 3'd0;
      repeat (3) begin
         @(negedge clk);
         chk("len0_no_busy", {30'd0, busy_if, busy_mem}, 32'd0);
         chk("len0_no_write", {31'd0, ram_rw}, 32'd0);
      end
      // A zero-length MEM request does not block a fetch.
      if_e    = 1'b1;
      if_addr = 32'h0000_0500;
      observe(1'b0, 1'b0, 32'h0000_0500, 32'd0, 4, idle);
      chk("len0_if_wins", idle, 0);
      if_e  = 1'b0;
      mem_e = 1'b0;
      idle_check();

      // Contention: MEM first, IF after DONE with one idle cycle.
      mem_e    = 1'b1;
      mem_rw   = 1'b0;
      mem_addr = 32'h0000_0100;
      mem_len  = 3'd4;
      if_e     = 1'b1;
      if_addr  = 32'h0000_0600;
      observe(1'b1, 1'b0, 32'h0000_0100, 32'd0, 4, idle);
      chk("contention_mem_first", idle, 0);
      mem_e = 1'b0;
      observe(1'b0, 1'b0, 32'h0000_0600, 32'd0, 4, idle);
      chk("contention_if_waits", idle, 1);
      if_e = 1'b0;
      idle_check();

      // Back-to-back fetches with IF_E held high.
      if_e    = 1'b1;
      if_addr = 32'h0000_0700;
      observe(1'b0, 1'b0, 32'h0000_0700, 32'd0, 4, idle);
      chk("b2b_first", idle, 0);
      if_addr = 32'h0000_0704;
      observe(1'b0, 1'b0, 32'h0000_0704, 32'd0, 4, idle);
      chk("b2b_second_gap", idle, 1);
      if_e = 1'b0;
      idle_check();

      // Randomized mix of fetches, reads and writes.
      for (int n = 0; n < 40; n++) begin
         kind   = $urandom_range(0, 2);
         r_addr = $urandom;
         r_data = $urandom;
         lenf   = 3'($urandom_range(1, 7));
         if ($urandom_range(0, 3) == 0) r_addr[16:0] = 17'h1FFFD;
         if (kind == 0) begin
            if_txn(r_addr);
         end else begin
            mem_txn(kind == 2, r_addr, r_data, lenf);
         end
      end

      // Reset in the middle of a word store after two bytes are written.
      mem_e    = 1'b1;
      mem_rw   = 1'b1;
      mem_addr = 32'h0000_0800;
      mem_data = 32'hA1B2_C3D4;
      mem_len  = 3'd4;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      mem_e = 1'b0;
      #1;
      reset_check();
      repeat (3) begin
         @(negedge clk);
         chk("abort_no_de", {30'd0, if_de, mem_de}, 32'd0);
         chk("abort_no_write", {31'd0, ram_rw}, 32'd0);
      end
      ref_mem[17'h800] = 8'hD4;
      ref_mem[17'h801] = 8'hC3;
      for (int k = 0; k < 4; k++) begin
         a = 17'h800 + 17'(k);
         chk("abort_ram", {24'd0, ram[a]}, {24'd0, ref_mem[a]});
      end
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      mem_txn(1'b0, 32'h0000_0800, 32'd0, 3'd4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
